// File: rtl/ariane_pkg.sv
// Minimal copy of the CVA6 exception type used on the MMU interface, so this
// block can be built without the full core package tree.
package ariane_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  localparam logic [63:0] LOAD_PAGE_FAULT  = 64'd13;
  localparam logic [63:0] STORE_PAGE_FAULT = 64'd15;

endpackage

// File: rtl/vlsu_mmu_requester_pkg.sv
// Shared types for the VLSU data-MMU requester: FSM states and the
// registered per-chunk response.
package vlsu_mmu_requester_pkg;

  localparam int unsigned PkgPaddrWidth = 56;
  localparam int unsigned PkgPageBits   = 12;
  localparam int unsigned PageSize      = 1 << PkgPageBits;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT
  } state_e;

  // Response fields are sized for the default address geometry.
  typedef struct packed {
    logic [PkgPaddrWidth-1:0] paddr;
    logic [PkgPageBits:0]     bytes;
    logic                     last;
    ariane_pkg::exception_t   exception;
    logic                     timeout;
  } resp_t;

endpackage

// File: rtl/vlsu_page_chunker.sv
// Combinational page splitter: the next chunk is whatever remains, capped at
// the distance to the next page boundary.
module vlsu_page_chunker
  import vlsu_mmu_requester_pkg::*;
#(
  parameter int unsigned LenWidth = 32,
  parameter int unsigned PageBits = 12
) (
  input  logic [PageBits-1:0] page_off_i,
  input  logic [LenWidth-1:0] remaining_i,
  output logic [PageBits:0]   bytes_o,
  output logic                last_o
);

  localparam logic [PageBits:0] PageSizeL = {1'b1, {PageBits{1'b0}}};

  logic [PageBits:0] room;
  logic [LenWidth-1:0] room_ext;

  always_comb begin
    room     = PageSizeL - {1'b0, page_off_i};
    room_ext = LenWidth'(room);
    last_o   = (remaining_i <= room_ext);
    bytes_o  = last_o ? remaining_i[PageBits:0] : room;
  end

endmodule

// File: rtl/vlsu_mmu_requester.sv
// VLSU data-MMU requester: splits an access into page chunks, translates each
// and streams results downstream. VLSU_MMU_REQUESTER_PERF_EN adds perf counters.
module vlsu_mmu_requester
  import vlsu_mmu_requester_pkg::*;
#(
  parameter int unsigned VaddrWidth    = 64,
  parameter int unsigned PaddrWidth    = PkgPaddrWidth,
  parameter int unsigned PageBits      = PkgPageBits,
  parameter int unsigned LenWidth      = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   translation_en_i,
  input  logic                   acc_valid_i,
  output logic                   acc_ready_o,
  input  logic [VaddrWidth-1:0]  acc_vaddr_i,
  input  logic [LenWidth-1:0]    acc_len_i,
  input  logic                   acc_is_store_i,
  output logic                   mmu_en_ld_st_translation_o,
  output logic                   mmu_req_o,
  output logic [VaddrWidth-1:0]  mmu_vaddr_o,
  output logic                   mmu_is_store_o,
  input  logic                   mmu_valid_i,
  input  logic [PaddrWidth-1:0]  mmu_paddr_i,
  input  ariane_pkg::exception_t mmu_exception_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [PaddrWidth-1:0]  resp_paddr_o,
  output logic [PageBits:0]      resp_bytes_o,
  output logic                   resp_last_o,
  output ariane_pkg::exception_t resp_exception_o,
  output logic                   resp_timeout_o,
  output logic                   spurious_valid_o,
  output logic [31:0]            perf_xlat_o,
  output logic [31:0]            perf_wait_o,
  output logic [31:0]            perf_exc_o
);

  localparam int unsigned TmoW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  state_e                state_q, state_d;
  logic [VaddrWidth-1:0] vaddr_q, vaddr_d;
  logic [LenWidth-1:0]   rem_q, rem_d;
  logic                  store_q, store_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  resp_t                 resp_q, resp_d;

  logic [PageBits:0] chunk_bytes;
  logic              chunk_last;
  logic              tmo_hit;

  vlsu_page_chunker #(
    .LenWidth (LenWidth),
    .PageBits (PageBits)
  ) u_chunker (
    .page_off_i  (vaddr_q[PageBits-1:0]),
    .remaining_i (rem_q),
    .bytes_o     (chunk_bytes),
    .last_o      (chunk_last)
  );

  assign tmo_hit = (tmo_q == TmoLast);

  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    rem_d   = rem_q;
    store_d = store_q;
    tmo_d   = tmo_q;
    resp_d  = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_valid_i) begin
          vaddr_d = acc_vaddr_i;
          rem_d   = acc_len_i;
          store_d = acc_is_store_i;
          resp_d  = '0;
          if (acc_len_i == '0) begin
            resp_d.last = 1'b1;
            state_d     = ST_OUT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        resp_d       = '0;
        resp_d.bytes = chunk_bytes;
        resp_d.last  = chunk_last;
        if (translation_en_i) begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end else begin
          resp_d.paddr = vaddr_q[PaddrWidth-1:0];
          state_d      = ST_OUT;
        end
      end
      ST_WAIT: begin
        // A real answer beats a timeout landing in the same cycle.
        if (mmu_valid_i) begin
          resp_d.paddr     = mmu_paddr_i;
          resp_d.exception = mmu_exception_i;
          resp_d.last      = chunk_last | mmu_exception_i.valid;
          state_d          = ST_OUT;
        end else if (tmo_hit) begin
          resp_d.timeout = 1'b1;
          resp_d.last    = 1'b1;
          state_d        = ST_OUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (resp_ready_i) begin
          if (resp_q.exception.valid || resp_q.timeout) begin
            rem_d   = '0;
            state_d = ST_IDLE;
          end else begin
            rem_d   = rem_q - LenWidth'(resp_q.bytes);
            vaddr_d = vaddr_q + VaddrWidth'(resp_q.bytes);
            state_d = resp_q.last ? ST_IDLE : ST_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      vaddr_q <= '0;
      rem_q   <= '0;
      store_q <= 1'b0;
      tmo_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      rem_q   <= rem_d;
      store_q <= store_d;
      tmo_q   <= tmo_d;
      resp_q  <= resp_d;
    end
  end

  assign acc_ready_o                = ~rst_i & (state_q == ST_IDLE);
  assign mmu_en_ld_st_translation_o = translation_en_i;
  assign mmu_req_o                  = ~rst_i & (state_q == ST_REQ) & translation_en_i;
  assign mmu_vaddr_o                = vaddr_q;
  assign mmu_is_store_o             = store_q;
  assign spurious_valid_o           = ~rst_i & mmu_valid_i & (state_q != ST_WAIT);
  assign resp_valid_o               = (state_q == ST_OUT);
  assign resp_paddr_o               = resp_q.paddr;
  assign resp_bytes_o               = resp_q.bytes;
  assign resp_last_o                = resp_q.last;
  assign resp_exception_o           = resp_q.exception;
  assign resp_timeout_o             = resp_q.timeout;

`ifdef VLSU_MMU_REQUESTER_PERF_EN
  logic [31:0] perf_xlat_q, perf_xlat_d;
  logic [31:0] perf_wait_q, perf_wait_d;
  logic [31:0] perf_exc_q, perf_exc_d;
  logic        exc_evt;

  assign exc_evt = (state_q == ST_WAIT) &
                   (mmu_valid_i ? mmu_exception_i.valid : tmo_hit);

  always_comb begin
    perf_xlat_d = perf_xlat_q;
    perf_wait_d = perf_wait_q;
    perf_exc_d  = perf_exc_q;
    if (mmu_req_o && perf_xlat_q != '1) perf_xlat_d = perf_xlat_q + 1'b1;
    if (state_q == ST_WAIT && perf_wait_q != '1) perf_wait_d = perf_wait_q + 1'b1;
    if (exc_evt && perf_exc_q != '1) perf_exc_d = perf_exc_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_xlat_q <= '0;
      perf_wait_q <= '0;
      perf_exc_q  <= '0;
    end else begin
      perf_xlat_q <= perf_xlat_d;
      perf_wait_q <= perf_wait_d;
      perf_exc_q  <= perf_exc_d;
    end
  end

  assign perf_xlat_o = perf_xlat_q;
  assign perf_wait_o = perf_wait_q;
  assign perf_exc_o  = perf_exc_q;
`else
  assign perf_xlat_o = '0;
  assign perf_wait_o = '0;
  assign perf_exc_o  = '0;
`endif

endmodule

// File: tb/tb_vlsu_mmu_requester.sv
// Directed bench for vlsu_mmu_requester with a hand-driven MMU responder.
module tb_vlsu_mmu_requester;
  import ariane_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        translation_en;
  logic        acc_valid;
  logic        acc_ready;
  logic [63:0] acc_vaddr;
  logic [31:0] acc_len;
  logic        acc_is_store;
  logic        mmu_en;
  logic        mmu_req;
  logic [63:0] mmu_vaddr;
  logic        mmu_is_store;
  logic        mmu_valid;
  logic [55:0] mmu_paddr;
  exception_t  mmu_exc;
  logic        resp_valid;
  logic        resp_ready;
  logic [55:0] resp_paddr;
  logic [12:0] resp_bytes;
  logic        resp_last;
  exception_t  resp_exc;
  logic        resp_timeout;
  logic        spurious;
  logic [31:0] perf_xlat, perf_wait, perf_exc;

  int checks = 0;
  int errors = 0;
  int req_cnt = 0;

  vlsu_mmu_requester #(.TimeoutCycles(16)) dut (
    .clk_i(clk), .rst_i(rst), .translation_en_i(translation_en),
    .acc_valid_i(acc_valid), .acc_ready_o(acc_ready), .acc_vaddr_i(acc_vaddr),
    .acc_len_i(acc_len), .acc_is_store_i(acc_is_store),
    .mmu_en_ld_st_translation_o(mmu_en), .mmu_req_o(mmu_req),
    .mmu_vaddr_o(mmu_vaddr), .mmu_is_store_o(mmu_is_store),
    .mmu_valid_i(mmu_valid), .mmu_paddr_i(mmu_paddr), .mmu_exception_i(mmu_exc),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_paddr_o(resp_paddr),
    .resp_bytes_o(resp_bytes), .resp_last_o(resp_last),
    .resp_exception_o(resp_exc), .resp_timeout_o(resp_timeout),
    .spurious_valid_o(spurious), .perf_xlat_o(perf_xlat), .perf_wait_o(perf_wait),
    .perf_exc_o(perf_exc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mmu_req === 1'b1) req_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE: present one access; returns one cycle later with the FSM past IDLE.
  task automatic start(input logic [63:0] va, input logic [31:0] len, input logic st);
    acc_valid = 1'b1; acc_vaddr = va; acc_len = len; acc_is_store = st;
    tick();
    acc_valid = 1'b0;
    #1;
  endtask

  // Called with the FSM in REQ: MMU answers one cycle after the request.
  task automatic xlat_chunk(input string tag, input logic [63:0] exp_va,
                            input logic [55:0] pa, input exception_t ex,
                            input logic [12:0] exp_bytes, input logic exp_last);
    chk({tag, "_req"}, mmu_req, 1'b1);
    chk({tag, "_vaddr"}, mmu_vaddr, exp_va);
    tick();
    chk({tag, "_req_pulse"}, mmu_req, 1'b0);
    mmu_valid = 1'b1; mmu_paddr = pa; mmu_exc = ex;
    #1;
    chk({tag, "_no_spurious"}, spurious, 1'b0);
    tick();
    mmu_valid = 1'b0; mmu_exc = '0;
    #1;
    chk({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_paddr"}, resp_paddr, pa);
    chk({tag, "_bytes"}, resp_bytes, exp_bytes);
    chk({tag, "_last"}, resp_last, exp_last);
    chk({tag, "_exc"}, resp_exc, ex);
    chk({tag, "_timeout"}, resp_timeout, 1'b0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
  endtask

  initial begin
    int r0;
    int n;
    exception_t noexc;
    exception_t pf;
    noexc = '0;
    pf.cause = LOAD_PAGE_FAULT; pf.tval = 64'h1000; pf.valid = 1'b1;

    rst = 1'b1; translation_en = 1'b1; acc_valid = 1'b0; acc_vaddr = '0;
    acc_len = '0; acc_is_store = 1'b0; mmu_valid = 1'b0; mmu_paddr = '0;
    mmu_exc = '0; resp_ready = 1'b0;
    tick(); tick();
    chk("rst_ready", acc_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_req", mmu_req, 1'b0);
    chk("rst_vaddr", mmu_vaddr, 64'h0);
    chk("rst_paddr", resp_paddr, 56'h0);
    chk("rst_last", resp_last, 1'b0);
    rst = 1'b0;
    #1;
    chk("idle_ready", acc_ready, 1'b1);

    // Single chunk inside one page.
    r0 = req_cnt;
    start(64'h1000, 32'd64, 1'b0);
    xlat_chunk("t1", 64'h1000, 56'h1000, noexc, 13'd64, 1'b1);
    chk("t1_idle", acc_ready, 1'b1);
    chk("t1_reqs", req_cnt - r0, 1);

    // Access straddling a page boundary.
    r0 = req_cnt;
    start(64'h1FF0, 32'h30, 1'b1);
    chk("t2_store", mmu_is_store, 1'b1);
    xlat_chunk("t2a", 64'h1FF0, 56'h5FF0, noexc, 13'h10, 1'b0);
    xlat_chunk("t2b", 64'h2000, 56'h6000, noexc, 13'h20, 1'b1);
    chk("t2_idle", acc_ready, 1'b1);
    chk("t2_reqs", req_cnt - r0, 2);

    // Page fault on the second chunk terminates the access.
    r0 = req_cnt;
    start(64'h0, 32'h3000, 1'b0);
    xlat_chunk("t3a", 64'h0, 56'h8000, noexc, 13'h1000, 1'b0);
    xlat_chunk("t3b", 64'h1000, 56'h9000, pf, 13'h1000, 1'b1);
    chk("t3_idle", acc_ready, 1'b1);
    tick(); tick(); tick();
    chk("t3_reqs", req_cnt - r0, 2);

    // MMU never answers.
    start(64'h4000, 32'd16, 1'b0);
    chk("t4_req", mmu_req, 1'b1);
    n = 0;
    do begin
      tick();
      n++;
    end while (resp_valid !== 1'b1 && n < 40);
    chk("t4_wait_cycles", n - 1, 16);
    chk("t4_timeout", resp_timeout, 1'b1);
    chk("t4_last", resp_last, 1'b1);
    chk("t4_exc", resp_exc.valid, 1'b0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("t4_idle", acc_ready, 1'b1);

    // Bypass with downstream backpressure.
    r0 = req_cnt;
    translation_en = 1'b0;
    start(64'hABC, 32'd8, 1'b0);
    chk("t5_en", mmu_en, 1'b0);
    chk("t5_no_req", mmu_req, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", resp_valid, 1'b1);
      chk("t5_hold_paddr", resp_paddr, 56'hABC);
      chk("t5_hold_bytes", resp_bytes, 13'd8);
      chk("t5_hold_last", resp_last, 1'b1);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    translation_en = 1'b1;
    #1;
    chk("t5_idle", acc_ready, 1'b1);
    chk("t5_reqs", req_cnt - r0, 0);

    // Zero-length access.
    r0 = req_cnt;
    start(64'h123, 32'd0, 1'b0);
    chk("t6_valid", resp_valid, 1'b1);
    chk("t6_bytes", resp_bytes, 13'd0);
    chk("t6_last", resp_last, 1'b1);
    chk("t6_paddr", resp_paddr, 56'h0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("t6_idle", acc_ready, 1'b1);
    chk("t6_reqs", req_cnt - r0, 0);

    // Reset while waiting; the late answer is flagged spurious.
    start(64'h7000, 32'd4, 1'b0);
    tick();
    chk("t7_waiting", resp_valid, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t7_idle", acc_ready, 1'b1);
    chk("t7_vaddr_clr", mmu_vaddr, 64'h0);
    mmu_valid = 1'b1; mmu_paddr = 56'h7000;
    #1;
    chk("t7_spurious", spurious, 1'b1);
    tick();
    chk("t7_no_resp", resp_valid, 1'b0);
    mmu_valid = 1'b0;
    #1;
    chk("t7_spurious_off", spurious, 1'b0);

    // Answer in the request cycle is ignored.
    start(64'h9000, 32'd4, 1'b0);
    mmu_valid = 1'b1; mmu_paddr = 56'hDEAD;
    #1;
    chk("t8_spurious", spurious, 1'b1);
    tick();
    mmu_valid = 1'b0;
    #1;
    chk("t8_ignored", resp_valid, 1'b0);
    mmu_valid = 1'b1; mmu_paddr = 56'h9000;
    tick();
    mmu_valid = 1'b0;
    #1;
    chk("t8_valid", resp_valid, 1'b1);
    chk("t8_paddr", resp_paddr, 56'h9000);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vlsu_mmu_requester.md
Name: vlsu_mmu_requester

Overview:
- Requester-side front end for the vector load/store unit's data-MMU port; the MMU is the responder.
- Accepts one memory access at a time: base vaddr, byte length, load/store.
- Splits the access into page-bounded chunks and issues one single-cycle translation request per chunk.
- Waits for the MMU answer, then hands each translated chunk, or the first exception, downstream over a valid/ready channel.

Parameters:
VaddrWidth, 64, virtual address width
PaddrWidth, 56, physical address width
PageBits, 12, log2 page size (4 KiB)
LenWidth, 32, access length width in bytes
TimeoutCycles, 1024, WAIT cycles before declaring MMU timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
translation_en_i  in  1  1: translate via MMU; 0: bypass, paddr = vaddr[PaddrWidth-1:0]
acc_valid_i  in  1  access request valid
acc_ready_o  out  1  access request ready (high only in IDLE)
acc_vaddr_i  in  VaddrWidth  base virtual address
acc_len_i  in  LenWidth  length in bytes
acc_is_store_i  in  1  store flag
mmu_en_ld_st_translation_o  out  1  equals translation_en_i
mmu_req_o  out  1  translation request, one-cycle pulse
mmu_vaddr_o  out  VaddrWidth  chunk vaddr, held stable from REQ through WAIT
mmu_is_store_o  out  1  latched store flag
mmu_valid_i  in  1  translation answer valid
mmu_paddr_i  in  PaddrWidth  translated address
mmu_exception_i  in  ariane_pkg::exception_t  translation exception
resp_valid_o  out  1  chunk result valid
resp_ready_i  in  1  chunk result ready
resp_paddr_o  out  PaddrWidth  chunk physical address
resp_bytes_o  out  PageBits+1  chunk length in bytes
resp_last_o  out  1  final chunk of the access, or terminating error
resp_exception_o  out  ariane_pkg::exception_t  exception of this chunk
resp_timeout_o  out  1  MMU gave no answer within TimeoutCycles
spurious_valid_o  out  1  pulse: mmu_valid_i seen outside WAIT

Behaviour:
- Reset values: every output 0; FSM in IDLE; all registers 0.
- FSM states: IDLE, REQ, WAIT, OUT.
- IDLE:
  - acc_ready_o=1.
  - On acc_valid_i, latch vaddr, remaining=len, is_store.
  - If len==0, go to OUT with paddr=0, bytes=0, last=1 and no MMU traffic.
  - Otherwise go to REQ.
- Chunk size: bytes = min(remaining, 2^PageBits - vaddr[PageBits-1:0]), computed from registered values. Max 4096, hence PageBits+1 bits.
- REQ, translation enabled: mmu_req_o=1 for exactly this cycle, then WAIT with timeout counter cleared.
- REQ, translation disabled: no request; paddr = vaddr truncated; go to OUT.
- WAIT:
  - Timeout counter increments each cycle.
  - On mmu_valid_i, capture paddr and exception; go to OUT.
  - If the counter reaches TimeoutCycles-1 without valid: go to OUT with resp_timeout_o=1 and last=1.
  - If valid and timeout occur in the same cycle, valid wins.
- Minimum latency: req in cycle N, earliest mmu_valid_i accepted is N+1. An answer in cycle N is ignored and flagged spurious.
- OUT: resp_valid_o=1; all resp_* held stable until resp_ready_i.
- On the OUT handshake:
  - Exception valid or timeout: last=1, remaining work discarded, go to IDLE.
  - Otherwise remaining -= bytes and vaddr += bytes, wrapping modulo 2^VaddrWidth.
  - Then go to IDLE if remaining==0 (last was 1), else REQ.
- resp_last_o = (remaining==bytes) || exception || timeout.
- spurious_valid_o is a one-cycle pulse whenever mmu_valid_i=1 and state != WAIT.
- translation_en_i is sampled per chunk in REQ. Changing it mid-access affects only later chunks.
- rst_i asserted in any state: IDLE next cycle, outputs 0, the in-flight MMU answer is dropped.

Optional Feature:
- Macro VLSU_MMU_REQUESTER_PERF_EN.
- When defined, adds 32-bit saturating counters:
  - perf_xlat_o: translations issued.
  - perf_wait_o: total WAIT cycles.
  - perf_exc_o: exceptions plus timeouts.
- Counters are cleared by rst_i.
- When undefined, the ports still exist and are tied to 0; no counter flops are built.

Decomposition:
- Package vlsu_mmu_requester_pkg holds:
  - state enum typedef;
  - resp struct typedef (paddr, bytes, last, exception, timeout);
  - constant PageSize = 1 << PageBits.
- One natural sub-module: vlsu_page_chunker. It is combinational: from vaddr and remaining it produces chunk bytes and last. Instantiated once.

Test Plan:
- vaddr=0x1000, len=64, MMU answers after 1 cycle with paddr=0x1000 -> one resp: paddr 0x1000, bytes 64, last=1; exactly one mmu_req_o pulse.
- vaddr=0x1FF0, len=0x30 -> two requests, at 0x1FF0 then 0x2000; resp bytes 0x10 (last=0), then 0x20 (last=1).
- vaddr=0x0, len=0x3000, exception on the second answer, cause LOAD_PAGE_FAULT, tval 0x1000 -> second resp has exception valid and last=1; no third request issued.
- MMU never answers, TimeoutCycles=16 -> resp_timeout_o=1 and last=1 exactly 16 cycles after mmu_req_o; FSM returns to IDLE.
- translation_en_i=0, vaddr=0xABC, len=8 -> no mmu_req_o; resp paddr 0xABC, bytes 8; resp_ready_i held low for 5 cycles -> outputs stable throughout.
- len=0 -> immediate resp with bytes 0, last=1; no MMU traffic. rst_i asserted during WAIT -> IDLE next cycle; late mmu_valid_i gives spurious_valid_o=1.
